booth_seq_multiplier: RTL

Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides. It is the sequential, parametrised successor to the team's combinational signed multiplier. It supports signed and unsigned operands selected per transaction and has a fixed multi-cycle latency. It sits in the arithmetic datapath wherever area matters more than single-cycle throughput.

---
 rtl/fast_arith_pkg.sv | 24 ++
 rtl/booth_digit_encoder.sv | 41 ++++
 rtl/booth_seq_multiplier.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fast_arith_pkg.sv
// Shared types and helpers for the arithmetic datapath blocks:
// FSM state encoding, Booth digit codes and the radix-4 step count.
package fast_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    // Operands carry two extension bits, so one extra radix-4 digit is needed.
    function automatic int booth_steps(input int input_length);
        return input_length / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth digit encoder: maps a 3-bit multiplier window and the
// extended multiplicand to a signed partial product one bit wider.
module booth_digit_encoder
    import fast_arith_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [2:0] i_bits,
    input  logic [W-1:0] i_a,
    output logic [W:0] o_pp
);

    booth_digit_t w_digit;
    logic [W:0] w_a1;

    assign w_a1 = {i_a[W-1], i_a};

    always_comb begin
        w_digit = ZERO;
        unique case (i_bits)
            3'b001, 3'b010: w_digit = POS1;
            3'b011:         w_digit = POS2;
            3'b100:         w_digit = NEG2;
            3'b101, 3'b110: w_digit = NEG1;
            default:        w_digit = ZERO;
        endcase
    end

    // The multiplicand already carries redundant sign bits, so 2A never overflows.
    always_comb begin
        o_pp = '0;
        unique case (w_digit)
            POS1:    o_pp = w_a1;
            POS2:    o_pp = w_a1 << 1;
            NEG1:    o_pp = -w_a1;
            NEG2:    o_pp = -(w_a1 << 1);
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define BOOTH_SATURATE_EN to clamp out-of-range products and flag oOverflow.
module booth_seq_multiplier
    import fast_arith_pkg::*;
#(
    parameter int INPUT_LENGTH  = 8,
    parameter int OUTPUT_LENGTH = 16
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [INPUT_LENGTH-1:0]  iA,
    input  logic [INPUT_LENGTH-1:0]  iB,
    input  logic                     iSigned,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [OUTPUT_LENGTH-1:0] oRes,
    output logic                     oOverflow,
    output logic [1:0]               oDbgState
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    localparam int EXT_W  = INPUT_LENGTH + 2;
    localparam int PP_W   = EXT_W + 1;
    localparam int ACC_W  = 2 * INPUT_LENGTH + 4;
    localparam int PROD_W = 2 * INPUT_LENGTH;
    localparam int N      = booth_steps(INPUT_LENGTH);
    localparam int CNT_W  = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [EXT_W-1:0]         r_a;
    logic [EXT_W-1:0]         r_b;
    logic [ACC_W-1:0]         r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [OUTPUT_LENGTH-1:0] r_res;
    logic                     r_ovf;
    logic                     w_accept;
    logic                     w_take;
    logic                     w_last;
    logic [EXT_W:0]           w_b_pad;
    logic [2:0]               w_bits;
    logic [PP_W-1:0]          w_pp;
    logic [ACC_W-1:0]         w_addend;
    logic [ACC_W-1:0]         w_acc_next;
    logic [OUTPUT_LENGTH-1:0] w_res_next;
    logic                     w_ovf_next;

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = BUSY;
            BUSY:    if (w_last)   w_state_next = DONE;
            DONE:    if (w_take)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (iRst) w_state_next = IDLE;
    end

    always_comb begin
        oReady   = (r_state == IDLE) && !iRst;
        oValid   = (r_state == DONE);
        w_accept = iValid && oReady;
        w_take   = oValid && iReady;
        w_last   = (r_state == BUSY) && (r_cnt == LAST_STEP);
    end

    assign oRes      = r_res;
    assign oOverflow = r_ovf;
    assign oDbgState = r_state;

    // b[-1] = 0 is appended below bit 0 so window i starts at bit 2i.
    assign w_b_pad = {r_b, 1'b0};
    assign w_bits  = w_b_pad[{r_cnt, 1'b0} +: 3];

    booth_digit_encoder #(.W(EXT_W)) u_enc (
        .i_bits (w_bits),
        .i_a    (r_a),
        .o_pp   (w_pp)
    );

    assign w_addend   = {{(ACC_W - PP_W){w_pp[PP_W-1]}}, w_pp} << {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_addend;

`ifdef BOOTH_SATURATE_EN
    logic                     r_signed;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_prod_hi;

    always_ff @(posedge iClk) begin
        if (iRst)          r_signed <= 1'b0;
        else if (w_accept) r_signed <= iSigned;
    end

    assign w_prod = w_acc_next[PROD_W-1:0];

    // Signed fit: every bit from OUTPUT_LENGTH-1 upward must equal the sign.
    always_comb begin
        w_prod_hi  = '0;
        w_res_next = w_prod[OUTPUT_LENGTH-1:0];
        w_ovf_next = 1'b0;
        if (r_signed) begin
            w_prod_hi = w_prod >>> (OUTPUT_LENGTH - 1);
            if (w_prod_hi != '0 && w_prod_hi != '1) begin
                w_ovf_next = 1'b1;
                w_res_next = w_prod[PROD_W-1] ? {1'b1, {(OUTPUT_LENGTH-1){1'b0}}}
                                              : {1'b0, {(OUTPUT_LENGTH-1){1'b1}}};
            end
        end else if ((w_prod >> OUTPUT_LENGTH) != '0) begin
            w_ovf_next = 1'b1;
            w_res_next = '1;
        end
    end
`else
    assign w_res_next = w_acc_next[OUTPUT_LENGTH-1:0];
    assign w_ovf_next = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_a   <= iSigned ? {{2{iA[INPUT_LENGTH-1]}}, iA} : {2'b00, iA};
            r_b   <= iSigned ? {{2{iB[INPUT_LENGTH-1]}}, iB} : {2'b00, iB};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_res <= w_res_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

endmodule
